// File: rtl/multicycle_ctrl_fsm_pkg.sv
// rtl/multicycle_ctrl_fsm_pkg.sv - state encodings, ResultSrc codes and per-state control words
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ALUWB2 = 4'd10,
    S_EXECF  = 4'd11,
    S_FWAIT  = 4'd12,
    S_FWB    = 4'd13,
    S_FAULT  = 4'd14
  } state_e;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_FPU       = 2'b11;

  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       mem_w;
    logic       reg_w;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic       lmul_flag;
    logic       fpu_start;
  } ctrl_word_t;

  // Field order: NextPC Branch MemW RegW IRWrite AdrSrc ResultSrc ALUSrcA ALUSrcB ALUOp LmulFlag FpuStart
  localparam ctrl_word_t CW_NONE   = 15'b0_0_0_0_0_0_00_00_00_0_0_0;
  localparam ctrl_word_t CW_FETCH  = 15'b1_0_0_0_1_0_10_01_10_0_0_0;
  localparam ctrl_word_t CW_DECODE = 15'b0_0_0_0_0_0_10_01_10_0_0_0;
  localparam ctrl_word_t CW_EXECR  = 15'b0_0_0_0_0_0_00_00_00_1_0_0;
  localparam ctrl_word_t CW_EXECI  = 15'b0_0_0_0_0_0_00_00_01_1_0_0;
  localparam ctrl_word_t CW_MEMADR = 15'b0_0_0_0_0_0_00_00_01_0_0_0;
  localparam ctrl_word_t CW_MEMRD  = 15'b0_0_0_0_0_1_00_00_00_0_0_0;
  localparam ctrl_word_t CW_MEMWR  = 15'b0_0_1_0_0_1_00_00_00_0_0_0;
  localparam ctrl_word_t CW_MEMWB  = 15'b0_0_0_1_0_0_01_00_00_0_0_0;
  localparam ctrl_word_t CW_ALUWB  = 15'b0_0_0_1_0_0_00_00_00_0_0_0;
  localparam ctrl_word_t CW_ALUWB2 = 15'b0_0_0_1_0_0_00_00_00_0_1_0;
  localparam ctrl_word_t CW_BRANCH = 15'b0_1_0_0_0_0_10_00_01_0_0_0;
  localparam ctrl_word_t CW_EXECF  = 15'b0_0_0_0_0_0_00_00_00_0_0_1;
  localparam ctrl_word_t CW_FWB    = 15'b0_0_0_1_0_0_11_00_00_0_0_0;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - decoder/memory/FPU inputs and datapath control outputs of the FSM
interface multicycle_ctrl_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       Long;
  logic       MemReady;
  logic       FpuDone;
  logic       IRWrite;
  logic       AdrSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       LmulFlag;
  logic       FpuStart;
  logic       Fault;
  logic [3:0] State;

  modport master (
    output Op, Funct, Long, MemReady, FpuDone,
    input  IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
    input  ALUSrcA, ALUSrcB, ResultSrc, LmulFlag, FpuStart, Fault, State
  );

  modport slave (
    input  Op, Funct, Long, MemReady, FpuDone,
    output IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
    output ALUSrcA, ALUSrcB, ResultSrc, LmulFlag, FpuStart, Fault, State
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_wait_counter.sv
// rtl/multicycle_ctrl_fsm_wait_counter.sv - FPU wait counter with clear, enable and terminal count
module multicycle_ctrl_fsm_wait_counter #(
  parameter int unsigned LIMIT = 64,
  parameter int unsigned W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TC_VAL = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle core control FSM with memory wait-states, FPU handshake and long-multiply writeback
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          FPU_EN        = 1'b1,
  parameter int unsigned FPU_TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_fsm_if.slave bus
);

  state_e     state_q, state_d;
  ctrl_word_t cw;
  logic       fault;
  logic       mem_ok;
  logic       wait_tc;
  logic       wait_clr;
  logic       wait_en;

  assign mem_ok   = !MEM_HANDSHAKE || bus.MemReady;
  assign wait_clr = (state_q == S_EXECF);
  assign wait_en  = (state_q == S_FWAIT) && !bus.FpuDone && !wait_tc;

  multicycle_ctrl_fsm_wait_counter #(
    .LIMIT (FPU_TIMEOUT)
  ) u_wait_counter (
    .clk    (clk),
    .resetn (reset),
    .clr    (wait_clr),
    .en     (wait_en),
    .tc     (wait_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: begin
            if (FPU_EN) state_d = S_EXECF;
            else        state_d = S_FAULT;
          end
        endcase
      end
      S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ok) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = bus.Long ? S_ALUWB2 : S_FETCH;
      S_ALUWB2,
      S_MEMWB,
      S_BRANCH,
      S_FWB:    state_d = S_FETCH;
      S_EXECF:  state_d = S_FWAIT;
      // A completing FPU beats the timeout when both land in the same cycle.
      S_FWAIT: begin
        if (bus.FpuDone)  state_d = S_FWB;
        else if (wait_tc) state_d = S_FAULT;
      end
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  always_comb begin
    cw    = CW_NONE;
    fault = 1'b0;
    case (state_q)
      S_FETCH: begin
        cw = CW_FETCH;
        // PC and IR update only on the cycle the fetch actually completes.
        if (!mem_ok) begin
          cw.next_pc  = 1'b0;
          cw.ir_write = 1'b0;
        end
      end
      S_DECODE: cw = CW_DECODE;
      S_EXECR:  cw = CW_EXECR;
      S_EXECI:  cw = CW_EXECI;
      S_MEMADR: cw = CW_MEMADR;
      S_MEMRD:  cw = CW_MEMRD;
      S_MEMWR:  cw = CW_MEMWR;
      S_MEMWB:  cw = CW_MEMWB;
      S_ALUWB:  cw = CW_ALUWB;
      S_ALUWB2: cw = CW_ALUWB2;
      S_BRANCH: cw = CW_BRANCH;
      S_EXECF:  cw = CW_EXECF;
      S_FWB:    cw = CW_FWB;
      S_FAULT:  fault = 1'b1;
      default:  cw = CW_NONE;
    endcase
  end

  assign bus.NextPC    = cw.next_pc;
  assign bus.Branch    = cw.branch;
  assign bus.MemW      = cw.mem_w;
  assign bus.RegW      = cw.reg_w;
  assign bus.IRWrite   = cw.ir_write;
  assign bus.AdrSrc    = cw.adr_src;
  assign bus.ResultSrc = cw.result_src;
  assign bus.ALUSrcA   = cw.alu_src_a;
  assign bus.ALUSrcB   = cw.alu_src_b;
  assign bus.ALUOp     = cw.alu_op;
  assign bus.LmulFlag  = cw.lmul_flag;
  assign bus.FpuStart  = cw.fpu_start;
  assign bus.Fault     = fault;
  assign bus.State     = state_q;

endmodule
